mux4_rr_arbiter: RTL and testbench

- Shares one 4:1 data mux between four requesters, using round-robin arbitration with a bounded burst length.
- Drives the mux select and a registered single-entry output stage with valid/ready handshake.
- Sits in front of the accumulation datapath and sequences which source feeds it each cycle.

---
 rtl/mux4_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Purpose: round-robin arbiter sharing one 4:1 data mux, bounded bursts, registered output stage.
// Latency: one IDLE arbitration cycle before each grant; gnt beat to out_valid is 1 cycle.
// Backpressure: out_ready low with out_valid high holds the output word and suppresses gnt.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  sel_nxt;
    logic [7:0]  burst_cnt, burst_cnt_nxt;
    logic        can_load;
    logic        beat;

    // First requester at or after p, wrapping 3 -> 0; only meaningful when r != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            sel       <= 2'd0;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sel_nxt       = sel;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_nxt       = rr_pick(req, ptr);
                    burst_cnt_nxt = 8'd0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                end
                // An owner that withdraws its request gives up the slot without a beat.
                if ((beat && burst_cnt == LAST_BEAT) || !req[sel]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state == GRANT);
        can_load = !out_valid || out_ready;
        gnt      = 4'b0000;
        if (busy && req[sel] && can_load) begin
            gnt[sel] = 1'b1;
        end
        beat = |gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (beat) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel*DATA_W +: DATA_W];
            out_src   <= sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  a_req, a_gnt;
    logic [31:0] a_din;
    logic [1:0]  a_sel, a_src;
    logic        a_ov, a_rdy, a_busy;
    logic [7:0]  a_dout;

    logic [3:0]  b_req, b_gnt;
    logic [31:0] b_din;
    logic [1:0]  b_sel, b_src;
    logic        b_ov, b_rdy, b_busy;
    logic [7:0]  b_dout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .in_data(a_din), .gnt(a_gnt),
        .sel(a_sel), .out_valid(a_ov), .out_data(a_dout), .out_src(a_src),
        .out_ready(a_rdy), .busy(a_busy)
    );

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .in_data(b_din), .gnt(b_gnt),
        .sel(b_sel), .out_valid(b_ov), .out_data(b_dout), .out_src(b_src),
        .out_ready(b_rdy), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 4'b0; a_din = 32'h0; a_rdy = 1'b0;
        b_req = 4'b0; b_din = 32'h0; b_rdy = 1'b0;
        #3;
        chk("rst_a_ov", a_ov, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_sel", a_sel, 0);
        chk("rst_a_dout", a_dout, 0);
        chk("rst_a_src", a_src, 0);
        chk("rst_b_ov", b_ov, 0);
        chk("rst_b_busy", b_busy, 0);
        tick;
        rst_n = 1'b1;

        // Single request from requester 2.
        a_req = 4'b0100; a_din[23:16] = 8'hA5; a_rdy = 1'b1;
        tick;
        chk("t1_sel", a_sel, 2);
        chk("t1_busy", a_busy, 1);
        chk("t1_gnt", a_gnt, 4'b0100);
        chk("t1_ov_pre", a_ov, 0);
        tick;
        chk("t1_ov", a_ov, 1);
        chk("t1_dout", a_dout, 8'hA5);
        chk("t1_src", a_src, 2);
        a_req = 4'b0000;
        #1;
        chk("t1_gnt_drop", a_gnt, 0);
        tick;
        chk("t1_release_busy", a_busy, 0);
        chk("t1_drain_ov", a_ov, 0);

        // Reset so the pointer restarts at 0, then all four request continuously.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a_req = 4'b1111; a_din = 32'h13121110;
        for (int n = 0; n < 5; n++) begin
            logic [1:0] k;
            logic [3:0] onehot;
            k = 2'(n % 4);
            onehot = 4'b0001 << k;
            tick;
            chk("rr_sel", a_sel, k);
            chk("rr_busy", a_busy, 1);
            chk("rr_gnt", a_gnt, onehot);
            chk("rr_gap_ov", a_ov, 0);
            for (int b = 0; b < 4; b++) begin
                tick;
                chk("rr_ov", a_ov, 1);
                chk("rr_src", a_src, k);
                chk("rr_dout", a_dout, 8'h10 + 8'(k));
                chk("rr_busy_burst", a_busy, (b == 3) ? 1'b0 : 1'b1);
            end
        end
        a_req = 4'b0000;
        tick;
        chk("rr_end_ov", a_ov, 0);
        chk("rr_end_busy", a_busy, 0);

        // Requester 0 alone with a stalled output; ptr is 1 here.
        a_req = 4'b0001; a_din = 32'h0000_0001;
        tick;
        chk("st_sel", a_sel, 0);
        chk("st_gnt", a_gnt, 4'b0001);
        tick;
        chk("st_dout1", a_dout, 1);
        a_din[7:0] = 8'd2; a_rdy = 1'b0;
        #1;
        chk("st_gnt_stall", a_gnt, 0);
        tick;
        chk("st_hold_ov", a_ov, 1);
        chk("st_hold_dout", a_dout, 1);
        chk("st_hold_busy", a_busy, 1);
        tick;
        chk("st_hold2_dout", a_dout, 1);
        chk("st_hold2_gnt", a_gnt, 0);
        a_rdy = 1'b1;
        #1;
        chk("st_resume_gnt", a_gnt, 4'b0001);
        for (int v = 2; v <= 4; v++) begin
            tick;
            chk("st_seq_dout", a_dout, 8'(v));
            chk("st_seq_ov", a_ov, 1);
            a_din[7:0] = 8'(v + 1);
        end
        chk("st_burst_end", a_busy, 0);
        a_req = 4'b0000;
        tick;
        chk("st_drain", a_ov, 0);

        // Owner 1 drops after two beats while 3 waits; ptr is 1 here.
        a_req = 4'b1010; a_din = 32'h3300_2100;
        tick;
        chk("dr_sel1", a_sel, 1);
        tick;
        chk("dr_beat1", a_dout, 8'h21);
        a_din[15:8] = 8'h22;
        tick;
        chk("dr_beat2", a_dout, 8'h22);
        a_req = 4'b1000;
        #1;
        chk("dr_gnt_off", a_gnt, 0);
        tick;
        chk("dr_release", a_busy, 0);
        chk("dr_hold_dout", a_dout, 8'h22);
        tick;
        chk("dr_sel3", a_sel, 3);
        chk("dr_busy3", a_busy, 1);
        tick;
        chk("dr_dout3", a_dout, 8'h33);
        chk("dr_src3", a_src, 3);
        chk("dr_ov3", a_ov, 1);

        // Asynchronous reset mid-burst with a valid output word.
        rst_n = 1'b0;
        #1;
        chk("ar_ov", a_ov, 0);
        chk("ar_gnt", a_gnt, 0);
        chk("ar_busy", a_busy, 0);
        chk("ar_sel", a_sel, 0);
        rst_n = 1'b1;
        a_req = 4'b0110;
        tick;
        chk("ar_restart_sel", a_sel, 1);
        a_req = 4'b0000;

        // MAX_BURST=1 alternation between requesters 1 and 3.
        b_req = 4'b1010; b_din = 32'hB300_B100; b_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] k;
            k = (n % 2 == 0) ? 2'd1 : 2'd3;
            tick;
            chk("mb1_sel", b_sel, k);
            chk("mb1_busy", b_busy, 1);
            chk("mb1_gap_ov", b_ov, 0);
            tick;
            chk("mb1_ov", b_ov, 1);
            chk("mb1_src", b_src, k);
            chk("mb1_dout", b_dout, (k == 2'd1) ? 8'hB1 : 8'hB3);
            chk("mb1_idle", b_busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
